// File: rtl/spram_4096_40bit_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : spram_4096_40bit_arb_if
//  Brief    : Bundle of the two requester ports, the shared read-response
//             port, the init flag and the single-port RAM connection used by
//             spram_4096_40bit_arb.
//  Revision : 1.0  initial release
// ============================================================================
interface spram_4096_40bit_arb_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 40
);

  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_wren;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_data;

  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_wren;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_data;

  // Read responses (data shared, qualified per requester)
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DWIDTH-1:0] rsp_data;

  // Memory clear complete
  logic              init_done;

  // Single-port RAM
  logic [AWIDTH-1:0] ram_address;
  logic              ram_wren;
  logic [DWIDTH-1:0] ram_data;
  logic [DWIDTH-1:0] ram_out;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_wren, req0_addr, req0_data,
    input  req1_valid, req1_wren, req1_addr, req1_data,
    input  ram_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output init_done,
    output ram_address, ram_wren, ram_data
  );

  // Requester / RAM side
  modport master (
    output req0_valid, req0_wren, req0_addr, req0_data,
    output req1_valid, req1_wren, req1_addr, req1_data,
    output ram_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  init_done,
    input  ram_address, ram_wren, ram_data
  );

endinterface
`default_nettype wire

// File: rtl/spram_4096_40bit_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spram_4096_40bit_arb
//  Brief    : Two-requester round-robin arbiter in front of a single-port RAM
//             with registered read data. After reset the whole RAM is cleared
//             to zero, one word per cycle, before any request is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module spram_4096_40bit_arb #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 40,
  parameter int NUM_WORDS = 4096
) (
  input  wire logic              clk,
  input  wire logic              reset,
  spram_4096_40bit_arb_if.slave  bus
);

  // The interface instance must be built with the same AWIDTH/DWIDTH.
  localparam logic [AWIDTH-1:0] c_LAST_ADDR = AWIDTH'(NUM_WORDS - 1);
  localparam logic [AWIDTH-1:0] c_ADDR_ONE  = AWIDTH'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_clr_addr;
  logic [AWIDTH-1:0] w_clr_addr_nxt;
  logic              r_init_done;
  logic              w_init_done_nxt;

  // r_last: 1 means requester 1 won the most recent granted cycle.
  logic              r_last;
  // One read may be in flight; r_rsp_owner names who receives it.
  logic              r_rsp_pend;
  logic              r_rsp_owner;

  logic              w_run;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_gnt_read;

  // Requests are only considered in RUN and never while reset is held, so a
  // request arriving during the clear simply waits with ready low.
  assign w_run  = (r_state == ST_RUN) && !reset;

  // Single requester wins outright; on a tie the one that did not win last.
  assign w_gnt0 = w_run && bus.req0_valid && (!bus.req1_valid ||  r_last);
  assign w_gnt1 = w_run && bus.req1_valid && (!bus.req0_valid || !r_last);

  assign w_gnt_read = (w_gnt0 && !bus.req0_wren) || (w_gnt1 && !bus.req1_wren);

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  // Response valids are masked by reset so a read granted just before reset
  // never shows up on the response port.
  assign bus.rsp0_valid = r_rsp_pend && !r_rsp_owner && !reset;
  assign bus.rsp1_valid = r_rsp_pend &&  r_rsp_owner && !reset;
  assign bus.rsp_data   = bus.ram_out;

  assign bus.init_done  = r_init_done;

  // State, clear address and init flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next state and RAM port drive: clear sweep in CLEAR, granted request in RUN.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_addr_nxt  = r_clr_addr;
    w_init_done_nxt = r_init_done;
    bus.ram_wren    = 1'b0;
    bus.ram_address = '0;
    bus.ram_data    = '0;

    case (r_state)
      ST_CLEAR: begin
        if (!reset) begin
          bus.ram_wren    = 1'b1;
          bus.ram_address = r_clr_addr;
        end
        // The clear address stops at the last word rather than wrapping.
        if (r_clr_addr == c_LAST_ADDR) begin
          w_state_nxt     = ST_RUN;
          w_init_done_nxt = 1'b1;
        end else begin
          w_clr_addr_nxt  = r_clr_addr + c_ADDR_ONE;
        end
      end

      ST_RUN: begin
        if (w_gnt0) begin
          bus.ram_wren    = bus.req0_wren;
          bus.ram_address = bus.req0_addr;
          bus.ram_data    = bus.req0_data;
        end else if (w_gnt1) begin
          bus.ram_wren    = bus.req1_wren;
          bus.ram_address = bus.req1_addr;
          bus.ram_data    = bus.req1_data;
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Round-robin pointer and read-response tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_rsp_pend  <= 1'b0;
      r_rsp_owner <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      r_rsp_pend <= w_gnt_read;
      if (w_gnt_read) begin
        r_rsp_owner <= w_gnt1;
      end
    end
  end

endmodule
`default_nettype wire
